// File: rtl/funnel_sched.sv
// funnel_sched: round-robin selector that steers a funnel onto one input at a
// time. A grant lasts for up to `quantum` dequeues, or until the granted
// input runs dry, whichever comes first.
module funnel_sched #(
  parameter int funnelWidth = 8,
  parameter int quantum     = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [funnelWidth-1:0] req,
  input  logic                   deq_fire,
  output logic                   select__ENA,
  output logic [31:0]            select_v,
  input  logic                   select__RDY,
  output logic                   grant_valid,
  output logic [3:0]             grant_index,
  output logic                   idle
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cur, cur_nxt;
  logic [3:0] last, last_nxt;
  logic [3:0] pick, idx;
  logic [7:0] count, count_nxt;
  logic [15:0] req_pad;
  logic       found;

  // Widen req to 16 bits so a 4-bit index covers the vector at any width.
  assign req_pad = 16'(req);

  // Rotating priority search: first set bit at or after last+1, with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < funnelWidth; k++) begin
      idx = 4'((int'(last) + 1 + k) % funnelWidth);
      if (!found && req_pad[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign select__ENA = (state == ISSUE);
  assign select_v    = {28'b0, cur};
  assign grant_valid = (state == GRANT) && req_pad[cur];
  assign grant_index = cur;
  assign idle        = (state == IDLE);

  // Next-state and datapath updates for the selection sequence.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    last_nxt  = last;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (|req) begin
          cur_nxt   = pick;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (select__RDY) state_nxt = SETTLE;
      end
      SETTLE: begin
        // Funnel latches the new index this cycle; no dequeue allowed yet.
        count_nxt = '0;
        state_nxt = GRANT;
      end
      GRANT: begin
        if (!req_pad[cur]) begin
          last_nxt  = cur;
          state_nxt = IDLE;
        end else if (deq_fire) begin
          count_nxt = count + 8'd1;
          if (count == 8'(quantum - 1)) begin
            last_nxt  = cur;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset seeds last so the first search starts at index 0.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cur   <= '0;
      count <= '0;
      last  <= 4'(funnelWidth - 1);
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      count <= count_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_funnel_sched.sv
// Directed bench for funnel_sched (funnelWidth=8, quantum=4): a cycle table
// for reset, backpressure, early-empty and mid-grant reset, then looped
// sequences for round-robin order and sparse requests.
module tb_funnel_sched;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [7:0]  req;
  logic        deq_fire;
  logic        select__RDY;
  logic        ena;
  logic [31:0] sel_v;
  logic        gv;
  logic [3:0]  gi;
  logic        idle;

  int total = 0;
  int bad   = 0;

  funnel_sched #(.funnelWidth(8), .quantum(4)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .deq_fire(deq_fire),
    .select__ENA(ena), .select_v(sel_v), .select__RDY(select__RDY),
    .grant_valid(gv), .grant_index(gi), .idle(idle)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       fire;
    logic       rdy;
    logic       ena;
    logic [3:0] v;
    logic       gv;
    logic [3:0] gi;
    logic       idle;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(logic r, logic [7:0] q, logic f, logic y,
                              logic e, logic [3:0] v, logic g, logic [3:0] i, logic d);
    vec_t t;
    t.rst_n = r; t.req = q; t.fire = f; t.rdy = y;
    t.ena = e; t.v = v; t.gv = g; t.gi = i; t.idle = d;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs mid-low phase and let outputs settle before sampling.
  task automatic drive(logic r, logic [7:0] q, logic f, logic y);
    @(negedge CLK);
    nRST = r; req = q; deq_fire = f; select__RDY = y;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, 8'hFF, 1'b0, 1'b1);
    chk("reset_outs", {61'b0, ena, gv, idle}, {61'b0, 3'b001});
  endtask

  initial begin
    int order[$];
    int acc[$];
    int fires[9];
    logic prev;

    nRST = 1'b0; req = 8'hFF; deq_fire = 1'b0; select__RDY = 1'b1;

    //          rst req    fire rdy   ena v  gv gi idle
    tv[0]  = mk(0, 8'hFF, 0, 1,      0, 0, 0, 0, 1);
    tv[1]  = mk(0, 8'hFF, 0, 1,      0, 0, 0, 0, 1);
    tv[2]  = mk(1, 8'hFF, 0, 1,      0, 0, 0, 0, 1);
    tv[3]  = mk(1, 8'hFF, 0, 1,      1, 0, 0, 0, 0);
    tv[4]  = mk(1, 8'hFF, 0, 1,      0, 0, 0, 0, 0);
    tv[5]  = mk(1, 8'hFF, 1, 1,      0, 0, 1, 0, 0);
    tv[6]  = mk(1, 8'hFF, 1, 1,      0, 0, 1, 0, 0);
    tv[7]  = mk(1, 8'hFF, 1, 1,      0, 0, 1, 0, 0);
    tv[8]  = mk(1, 8'hFF, 1, 1,      0, 0, 1, 0, 0);
    tv[9]  = mk(1, 8'hFF, 0, 1,      0, 0, 0, 0, 1);
    tv[10] = mk(1, 8'hFF, 0, 0,      1, 1, 0, 1, 0);
    tv[11] = mk(1, 8'h0A, 0, 0,      1, 1, 0, 1, 0);
    tv[12] = mk(1, 8'h0A, 0, 0,      1, 1, 0, 1, 0);
    tv[13] = mk(1, 8'h0A, 0, 1,      1, 1, 0, 1, 0);
    tv[14] = mk(1, 8'h0A, 1, 1,      0, 1, 0, 1, 0);
    tv[15] = mk(1, 8'h0A, 1, 1,      0, 1, 1, 1, 0);
    tv[16] = mk(1, 8'h0A, 1, 1,      0, 1, 1, 1, 0);
    tv[17] = mk(1, 8'h08, 1, 1,      0, 1, 0, 1, 0);
    tv[18] = mk(1, 8'h08, 0, 1,      0, 1, 0, 1, 1);
    tv[19] = mk(1, 8'h08, 0, 1,      1, 3, 0, 3, 0);
    tv[20] = mk(1, 8'h08, 0, 1,      0, 3, 0, 3, 0);
    tv[21] = mk(1, 8'h08, 1, 1,      0, 3, 1, 3, 0);
    tv[22] = mk(1, 8'h08, 1, 1,      0, 3, 1, 3, 0);
    tv[23] = mk(0, 8'h08, 1, 1,      0, 3, 1, 3, 0);
    tv[24] = mk(1, 8'hFF, 0, 1,      0, 0, 0, 0, 1);
    tv[25] = mk(1, 8'hFF, 0, 1,      1, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tv[i].rst_n, tv[i].req, tv[i].fire, tv[i].rdy);
      chk($sformatf("vec%0d", i),
          {20'b0, ena, sel_v, gv, gi, idle},
          {20'b0, tv[i].ena, 28'b0, tv[i].v, tv[i].gv, tv[i].gi, tv[i].idle});
    end

    // Round-robin over all eight inputs with deq_fire following grant_valid.
    do_reset();
    prev = 1'b0;
    for (int g = 0; g < 9; g++) fires[g] = 0;
    for (int c = 0; c < 400 && order.size() < 9; c++) begin
      drive(1'b1, 8'hFF, 1'b0, 1'b1);
      deq_fire = gv;
      if (gv && !prev) order.push_back(int'(gi));
      if (gv && order.size() > 0) fires[order.size()-1]++;
      prev = gv;
    end
    chk("rr_grants", 64'(order.size()), 64'd9);
    for (int g = 0; g < order.size(); g++) begin
      chk($sformatf("rr_order%0d", g), 64'(order[g]), 64'(g % 8));
      if (g < 8) chk($sformatf("rr_fires%0d", g), 64'(fires[g]), 64'd4);
    end

    // Sparse requests: only inputs 2 and 5 may ever be selected.
    deq_fire = 1'b0;
    do_reset();
    for (int c = 0; c < 400 && acc.size() < 4; c++) begin
      drive(1'b1, 8'h24, 1'b0, 1'b1);
      deq_fire = gv;
      if (ena && select__RDY) acc.push_back(int'(sel_v));
    end
    chk("sparse_count", 64'(acc.size()), 64'd4);
    for (int k = 0; k < acc.size(); k++)
      chk($sformatf("sparse%0d", k), 64'(acc[k]), (k % 2 == 0) ? 64'd2 : 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
